// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM boundary skid buffer with BEQ/BNE resolution.
// Define EX_MEM_PERF_CNT_EN to add accept/stall performance counters.
module ex_mem_stage #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_c,
   input  logic            in_z,
   input  logic [RD_W-1:0] in_rd,
   input  logic            in_reg_write,
   input  logic            in_is_branch,
   input  logic            in_branch_ne,
   input  logic [XLEN-1:0] in_pc_target,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_c,
   output logic [RD_W-1:0] out_rd,
   output logic            out_reg_write,
   output logic            br_taken,
   output logic [XLEN-1:0] br_target
`ifdef EX_MEM_PERF_CNT_EN
   ,
   output logic [31:0]     perf_accepts,
   output logic [31:0]     perf_stalls
`endif
);
   // Encoding chosen so out_valid and in_ready come straight from state bits.
   typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
   state_t state, state_nx;
   logic accept, pop, taken, load_main, load_skid, skid_to_main;
   logic [XLEN-1:0] skid_c;
   logic [RD_W-1:0] skid_rd;
   logic skid_we;
   assign in_ready  = ~state[1];
   assign out_valid = state[0];
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign taken     = accept & ~flush & in_is_branch & (in_z ^ in_branch_ne);
   always_comb begin
      state_nx     = state;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush) state_nx = EMPTY;
      else
         case (state)
            EMPTY: if (accept) begin
               state_nx  = ONE;
               load_main = 1'b1;
            end
            ONE: if (accept & pop) load_main = 1'b1;
            else if (accept) begin
               state_nx  = FULL;
               load_skid = 1'b1;
            end
            else if (pop) state_nx = EMPTY;
            FULL: if (pop) begin
               state_nx     = ONE;
               skid_to_main = 1'b1;
            end
            default: state_nx = EMPTY;
         endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= EMPTY;
         out_c         <= '0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         skid_c        <= '0;
         skid_rd       <= '0;
         skid_we       <= 1'b0;
         br_taken      <= 1'b0;
         br_target     <= '0;
      end else begin
         state    <= state_nx;
         br_taken <= taken;
         if (taken) br_target <= in_pc_target;
         if (load_main) begin
            out_c         <= in_c;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write & ~in_is_branch;
         end else if (skid_to_main) begin
            out_c         <= skid_c;
            out_rd        <= skid_rd;
            out_reg_write <= skid_we;
         end
         if (load_skid) begin
            skid_c  <= in_c;
            skid_rd <= in_rd;
            skid_we <= in_reg_write & ~in_is_branch;
         end
      end
   end
`ifdef EX_MEM_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_accepts <= '0;
         perf_stalls  <= '0;
      end else begin
         perf_accepts <= perf_accepts + {31'd0, accept};
         perf_stalls  <= perf_stalls + {31'd0, in_valid & ~in_ready};
      end
   end
`endif
endmodule
